// File: rtl/rx_arb_pkg.sv
// rtl/rx_arb_pkg.sv - shared state encoding, default sizing and helpers for the RX port arbiter
package rx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int RX_ARB_MAX_LEN = 1518;
    localparam int RX_ARB_LEN_W   = 16;

    // Next port index after p, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder
//
// Returns the first asserted requester found scanning upward from ptr,
// wrapping modulo N_PORTS.
//   req    in   N_PORTS  request vector
//   ptr    in   PORT_W   highest-priority index
//   found  out  1        any request present
//   idx    out  PORT_W   winning index (0 when nothing found)
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int PORT_W  = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PORT_W-1:0]  ptr,
    output logic               found,
    output logic [PORT_W-1:0]  idx
);

    always_comb begin
        logic [PORT_W-1:0] cand;
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest candidate back toward ptr so the nearest
        // asserted requester is written last and wins.
        for (int off = N_PORTS - 1; off >= 0; off--) begin
            cand = PORT_W'((int'(ptr) + off) % N_PORTS);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mac_rx_port_arbiter.sv
// rtl/mac_rx_port_arbiter.sv - packet-granular round-robin arbiter of MAC RX FIFOs into the header buffer
//
// A port keeps the grant from its first byte until its last byte is
// accepted, so frames never interleave. One idle cycle per frame is spent
// arbitrating; the data path is combinational while a port is granted.
//
// Optional feature macro: RX_ARB_MAXLEN_EN (frame truncation at MAX_LEN
// bytes, with the remainder of the frame drained and discarded).
//
//   clk        in   1          system clock, rising edge
//   rst        in   1          synchronous active-high reset
//   in_valid   in   N_PORTS    per-port byte valid
//   in_data    in   8*N_PORTS  per-port byte, port k at [8k+7:8k]
//   in_last    in   N_PORTS    per-port end-of-frame
//   in_ready   out  N_PORTS    per-port accept (granted port only)
//   out_valid  out  1          merged byte valid
//   out_data   out  8          merged byte (0x00 outside PASS)
//   out_last   out  1          merged end-of-frame
//   out_ready  in   1          downstream accept
//   out_port   out  PORT_W     currently granted port
//   trunc_evt  out  1          one-cycle pulse after a truncating byte
module mac_rx_port_arbiter
    import rx_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int PORT_W  = 2,
    parameter int MAX_LEN = RX_ARB_MAX_LEN,
    parameter int LEN_W   = RX_ARB_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PORTS-1:0]     in_valid,
    input  logic [8*N_PORTS-1:0]   in_data,
    input  logic [N_PORTS-1:0]     in_last,
    output logic [N_PORTS-1:0]     in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [PORT_W-1:0]      out_port,
    output logic                   trunc_evt
);

    arb_state_t        state, state_next;
    logic [PORT_W-1:0] gnt, gnt_next;
    logic [PORT_W-1:0] rr_ptr, rr_next;
    logic [LEN_W-1:0]  byte_cnt, cnt_next;

    logic              pick_found;
    logic [PORT_W-1:0] pick_idx;

    logic              sel_valid;
    logic [7:0]        sel_data;
    logic              sel_last;
    logic [PORT_W-1:0] gnt_inc;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .PORT_W  (PORT_W)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign sel_valid = in_valid[gnt];
    assign sel_data  = in_data[{gnt, 3'b000} +: 8];
    assign sel_last  = in_last[gnt];
    assign gnt_inc   = PORT_W'(wrap_inc(int'(gnt), N_PORTS));
    assign out_port  = gnt;

`ifdef RX_ARB_MAXLEN_EN
    logic trunc_q, trunc_next;
    assign trunc_evt = trunc_q;
`else
    logic unused_cfg;
    assign trunc_evt  = 1'b0;
    assign unused_cfg = ^(LEN_W'(MAX_LEN));
`endif

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        rr_next    = rr_ptr;
        cnt_next   = byte_cnt;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        in_ready   = '0;
`ifdef RX_ARB_MAXLEN_EN
        trunc_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_next   = pick_idx;
                    cnt_next   = '0;
                    state_next = PASS;
                end
            end
            PASS: begin
                out_valid     = sel_valid;
                out_data      = sel_data;
                out_last      = sel_last;
                in_ready[gnt] = out_ready;
                if (sel_valid && out_ready) begin
                    if (byte_cnt != '1) begin
                        cnt_next = byte_cnt + 1'b1;
                    end
`ifdef RX_ARB_MAXLEN_EN
                    // byte_cnt counts bytes already accepted, so this fire is
                    // byte number MAX_LEN; a natural end here is not a cut.
                    if (!sel_last && byte_cnt == LEN_W'(MAX_LEN - 1)) begin
                        out_last   = 1'b1;
                        trunc_next = 1'b1;
                        state_next = DRAIN;
                    end else
`endif
                    if (sel_last) begin
                        rr_next    = gnt_inc;
                        state_next = IDLE;
                    end
                end
            end
`ifdef RX_ARB_MAXLEN_EN
            DRAIN: begin
                in_ready[gnt] = 1'b1;
                if (sel_valid && sel_last) begin
                    rr_next    = gnt_inc;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            byte_cnt <= '0;
`ifdef RX_ARB_MAXLEN_EN
            trunc_q  <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            rr_ptr   <= rr_next;
            byte_cnt <= cnt_next;
`ifdef RX_ARB_MAXLEN_EN
            trunc_q  <= trunc_next;
`endif
        end
    end

endmodule

// File: tb/tb_mac_rx_port_arbiter.sv
// tb/tb_mac_rx_port_arbiter.sv - self-checking bench for mac_rx_port_arbiter
module tb_mac_rx_port_arbiter;

    localparam int NP = 4;
`ifdef RX_ARB_MAXLEN_EN
    localparam int TB_MAX_LEN = 16;
    localparam bit TRUNC_ON   = 1'b1;
`else
    localparam int TB_MAX_LEN = 1518;
    localparam bit TRUNC_ON   = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   in_valid, in_last, in_ready;
    logic [8*NP-1:0] in_data;
    logic            out_valid, out_last, out_ready, trunc_evt;
    logic [7:0]      out_data;
    logic [1:0]      out_port;

    always #5 clk = ~clk;

    mac_rx_port_arbiter #(
        .N_PORTS (NP),
        .PORT_W  (2),
        .MAX_LEN (TB_MAX_LEN),
        .LEN_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_port  (out_port),
        .trunc_evt (trunc_evt)
    );

    int checks = 0;
    int errors = 0;

    // Source frames per port as {last, data}; exp_q mirrors what should emerge.
    logic [8:0] src[NP][$];
    logic [8:0] exp_q[NP][$];
    logic [NP-1:0] hold;
    int  stall_pct;
    int  rdy_mode;
    logic tog;
    logic rst_req;

    logic [NP-1:0] o_in_valid, o_in_ready;
    logic o_out_valid, o_out_ready, o_out_last, o_trunc, o_fire;
    logic [7:0] o_out_data;
    logic [1:0] o_out_port;

    task automatic push_frame(input int port, input int len, input int tag);
        logic [8:0] s;
        for (int i = 0; i < len; i++) begin
            s = {(i == len - 1), 8'(tag * 37 + i * 13 + port)};
            src[port].push_back(s);
            exp_q[port].push_back(s);
        end
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NP; k++) begin
            src[k].delete();
            exp_q[k].delete();
        end
    endtask

    function automatic logic [8:0] pop_exp(input int port);
        if (exp_q[port].size() > 0) return exp_q[port].pop_front();
        return 9'h1ff;
    endfunction

    // One clock: drive just after the rising edge, sample on the falling edge,
    // retire accepted source bytes at the next rising edge.
    task automatic step();
        #1;
        rst = rst_req;
        for (int k = 0; k < NP; k++) begin
            if (src[k].size() > 0 && !hold[k] && ($urandom_range(99) >= stall_pct)) begin
                in_valid[k]       = 1'b1;
                in_data[8*k +: 8] = src[k][0][7:0];
                in_last[k]        = src[k][0][8];
            end else begin
                in_valid[k]       = 1'b0;
                in_data[8*k +: 8] = 8'($urandom);
                in_last[k]        = 1'($urandom);
            end
        end
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin tog = ~tog; out_ready = tog; end
            default: out_ready = ($urandom_range(99) < 70);
        endcase
        @(negedge clk);
        o_in_valid  = in_valid;
        o_in_ready  = in_ready;
        o_out_valid = out_valid;
        o_out_ready = out_ready;
        o_out_data  = out_data;
        o_out_last  = out_last;
        o_out_port  = out_port;
        o_trunc     = trunc_evt;
        o_fire      = out_valid && out_ready;
        @(posedge clk);
        for (int k = 0; k < NP; k++) begin
            if (o_in_valid[k] && o_in_ready[k] && src[k].size() > 0) void'(src[k].pop_front());
        end
    endtask

    task automatic do_reset();
        #1;
        rst_req = 1'b1; rst = 1'b1;
        hold = '0; stall_pct = 0; rdy_mode = 0; tog = 1'b0;
        clear_sources();
        in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_req = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst_req = 1'b1; rst = 1'b1;
        in_valid = '1; in_data = {$urandom}; in_last = '1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
        checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL reset_out_port got %0d exp 0", out_port); end
        checks++; if (trunc_evt !== 1'b0) begin errors++; $display("FAIL reset_trunc_evt got %b exp 0", trunc_evt); end
        do_reset();
    endtask

    task automatic test_single_port();
        int n = 0;
        int cyc = 0;
        logic [8:0] e;
        do_reset();
        push_frame(2, 64, 1);
        while (src[2].size() > 0 && cyc < 300) begin
            step(); cyc++;
            if (o_fire) begin
                e = pop_exp(2); n++;
                checks++; if ({o_out_last, o_out_data} !== e) begin errors++; $display("FAIL single_byte %0d got %h exp %h", n, {o_out_last, o_out_data}, e); end
                checks++; if (o_out_port !== 2'd2) begin errors++; $display("FAIL single_port got %0d exp 2", o_out_port); end
            end
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL single_count got %0d exp 64", n); end
        // rr_ptr now points at 3: with 0 and 3 both requesting, 3 must win.
        push_frame(0, 1, 2);
        push_frame(3, 1, 2);
        cyc = 0;
        do begin step(); cyc++; end while (!o_fire && cyc < 20);
        checks++; if (!o_fire || o_out_port !== 2'd3) begin errors++; $display("FAIL single_rr_next fire %b port %0d exp port 3", o_fire, o_out_port); end
    endtask

    task automatic test_fairness();
        int order[$];
        int cyc = 0;
        int last_cyc = 0;
        logic in_frame = 1'b0;
        logic [8:0] e;
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < NP; k++) push_frame(k, 10, 10 + j);
        while ((src[0].size() + src[1].size() + src[2].size() + src[3].size()) > 0 && cyc < 500) begin
            step(); cyc++;
            if (o_fire) begin
                if (!in_frame) begin
                    order.push_back(int'(o_out_port));
                    if (order.size() > 1) begin
                        checks++; if (cyc - last_cyc !== 2) begin errors++; $display("FAIL fair_gap got %0d exp 2", cyc - last_cyc); end
                    end
                end
                e = pop_exp(int'(o_out_port));
                checks++; if ({o_out_last, o_out_data} !== e) begin errors++; $display("FAIL fair_byte got %h exp %h", {o_out_last, o_out_data}, e); end
                in_frame = !o_out_last;
                last_cyc = cyc;
            end
        end
        checks++; if (order.size() !== 8) begin errors++; $display("FAIL fair_frames got %0d exp 8", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            checks++; if (order[i] !== i % NP) begin errors++; $display("FAIL fair_order idx %0d got %0d exp %0d", i, order[i], i % NP); end
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        int n = 0;
        int first_cyc = -1;
        int span = 0;
        int exp_span = 0;
        logic [8:0] e;
        do_reset();
        rdy_mode = 1;
        push_frame(0, 20, 20);
        while (n < 20 && cyc < 200) begin
            step(); cyc++;
            if (o_out_valid && first_cyc < 0) begin
                first_cyc = cyc;
                exp_span = o_out_ready ? 39 : 40;
            end
            if (first_cyc >= 0) begin
                checks++; if (o_in_ready !== {3'b000, o_out_ready}) begin errors++; $display("FAIL bp_in_ready got %b exp %b", o_in_ready, {3'b000, o_out_ready}); end
            end
            if (o_fire) begin
                e = pop_exp(0); n++;
                checks++; if ({o_out_last, o_out_data} !== e) begin errors++; $display("FAIL bp_byte %0d got %h exp %h", n, {o_out_last, o_out_data}, e); end
                if (n == 20) span = cyc - first_cyc + 1;
            end
        end
        checks++; if (n !== 20) begin errors++; $display("FAIL bp_count got %0d exp 20", n); end
        checks++; if (span !== exp_span) begin errors++; $display("FAIL bp_span got %0d exp %0d", span, exp_span); end
    endtask

    task automatic test_no_interleave();
        int cyc = 0;
        int fires = 0;
        int stall_left = 5;
        int ep;
        logic [8:0] e;
        do_reset();
        push_frame(1, 12, 30);
        while ((src[0].size() + src[1].size()) > 0 && cyc < 200) begin
            if (fires == 4 && stall_left > 0) begin hold[1] = 1'b1; stall_left--; end
            else hold[1] = 1'b0;
            step(); cyc++;
            if (hold[1]) begin
                checks++; if (o_out_valid !== 1'b0 || o_in_ready !== 4'b0010 || o_out_port !== 2'd1) begin
                    errors++; $display("FAIL stall_hold valid %b in_ready %b port %0d exp 0 0010 1", o_out_valid, o_in_ready, o_out_port);
                end
            end
            if (o_fire) begin
                ep = (fires < 12) ? 1 : 0;
                e = pop_exp(ep);
                checks++; if (o_out_port !== 2'(ep) || {o_out_last, o_out_data} !== e) begin
                    errors++; $display("FAIL interleave_byte %0d port %0d data %h exp port %0d data %h", fires, o_out_port, {o_out_last, o_out_data}, ep, e);
                end
                fires++;
                if (fires == 1) push_frame(0, 3, 31);
            end
        end
        checks++; if (fires !== 15) begin errors++; $display("FAIL interleave_count got %0d exp 15", fires); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int fires = 0;
        do_reset();
        push_frame(1, 10, 40);
        while (fires < 4 && cyc < 50) begin
            step(); cyc++;
            if (o_fire) fires++;
        end
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        clear_sources();
        push_frame(0, 2, 41);
        push_frame(1, 2, 42);
        step();
        checks++; if ({o_out_valid, o_out_data, o_out_last, o_in_ready, o_out_port, o_trunc} !== 17'd0) begin
            errors++; $display("FAIL rstmid_outputs valid %b data %h last %b in_ready %b port %0d trunc %b exp all 0",
                               o_out_valid, o_out_data, o_out_last, o_in_ready, o_out_port, o_trunc);
        end
        cyc = 0;
        do begin step(); cyc++; end while (!o_fire && cyc < 20);
        checks++; if (!o_fire || o_out_port !== 2'd0) begin errors++; $display("FAIL rstmid_winner fire %b port %0d exp port 0", o_fire, o_out_port); end
    endtask

    task automatic test_trunc();
        int len, fires, last_at, tc, exp_fires, exp_tc;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            len = (t == 0) ? 20 : 16;
            fires = 0; last_at = 0; tc = 0;
            push_frame(3, len, 50 + t);
            for (int c = 0; c < 60; c++) begin
                step();
                if (o_fire) begin
                    fires++;
                    if (o_out_last) last_at = fires;
                end
                if (o_trunc) tc++;
            end
            exp_fires = (TRUNC_ON && len > TB_MAX_LEN) ? TB_MAX_LEN : len;
            exp_tc    = (TRUNC_ON && len > TB_MAX_LEN) ? 1 : 0;
            checks++; if (fires !== exp_fires) begin errors++; $display("FAIL trunc_fires len %0d got %0d exp %0d", len, fires, exp_fires); end
            checks++; if (last_at !== exp_fires) begin errors++; $display("FAIL trunc_last len %0d got %0d exp %0d", len, last_at, exp_fires); end
            checks++; if (tc !== exp_tc) begin errors++; $display("FAIL trunc_evt len %0d got %0d exp %0d", len, tc, exp_tc); end
            checks++; if (src[3].size() !== 0 || o_out_valid !== 1'b0) begin
                errors++; $display("FAIL trunc_drain len %0d left %0d valid %b exp 0 0", len, src[3].size(), o_out_valid);
            end
        end
    endtask

    // Frame-level reference: an idle cycle grants the first requester from
    // the rotating pointer; a granted port passes straight through until its
    // last byte is accepted, then the pointer moves past it.
    task automatic test_random();
        int cyc = 0;
        int tag = 60;
        logic m_busy = 1'b0;
        int m_port = 0;
        int m_rr = 0;
        int p;
        logic [8:0] e;
        do_reset();
        stall_pct = 25;
        rdy_mode = 2;
        for (int k = 0; k < NP; k++)
            for (int j = 0; j < int'($urandom_range(4, 1)); j++) begin
                push_frame(k, int'($urandom_range(15, 1)), tag); tag++;
            end
        while (((src[0].size() + src[1].size() + src[2].size() + src[3].size()) > 0 || m_busy) && cyc < 5000) begin
            step(); cyc++;
            checks++; if (o_trunc !== 1'b0) begin errors++; $display("FAIL rand_trunc got %b exp 0", o_trunc); end
            if (!m_busy) begin
                checks++; if (o_out_valid !== 1'b0 || o_out_data !== 8'h00 || o_in_ready !== 4'b0000) begin
                    errors++; $display("FAIL rand_idle valid %b data %h in_ready %b exp 0 00 0000", o_out_valid, o_out_data, o_in_ready);
                end
                for (int off = NP - 1; off >= 0; off--) begin
                    p = (m_rr + off) % NP;
                    if (o_in_valid[p]) begin m_busy = 1'b1; m_port = p; end
                end
            end else begin
                checks++; if (o_out_port !== 2'(m_port) || o_out_valid !== o_in_valid[m_port] ||
                              o_in_ready !== (o_out_ready ? 4'(1 << m_port) : 4'b0000)) begin
                    errors++; $display("FAIL rand_pass port %0d valid %b in_ready %b exp port %0d valid %b ready_in %b",
                                       o_out_port, o_out_valid, o_in_ready, m_port, o_in_valid[m_port], o_out_ready);
                end
                if (o_fire) begin
                    e = pop_exp(m_port);
                    checks++; if ({o_out_last, o_out_data} !== e) begin errors++; $display("FAIL rand_byte port %0d got %h exp %h", m_port, {o_out_last, o_out_data}, e); end
                    if (e[8]) begin m_busy = 1'b0; m_rr = (m_port + 1) % NP; end
                end
            end
        end
        checks++; if (cyc >= 5000) begin errors++; $display("FAIL rand_timeout cycles %0d limit 5000", cyc); end
        checks++; if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) !== 0) begin
            errors++; $display("FAIL rand_leftover got %0d exp 0", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
        end
    endtask

    initial begin
        rst = 1'b1; rst_req = 1'b1;
        in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
        hold = '0; stall_pct = 0; rdy_mode = 0; tog = 1'b0;
        test_reset();
        test_single_port();
        test_fairness();
        test_backpressure();
        test_no_interleave();
        test_reset_mid();
        test_trunc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
